// File: rtl/hci_core_resp_tracking_arbiter_pkg.sv
// Shared widths, the in-flight transaction ID type and a saturating counter
// helper for the HCI core response-tracking arbiter.
package hci_core_resp_tracking_arbiter_pkg;

  localparam int HCI_ARB_MAX_INIT = 16;
  localparam int HCI_ARB_IDX_W    = $clog2(HCI_ARB_MAX_INIT);

  localparam int HCI_DW = 32;
  localparam int HCI_AW = 32;
  localparam int HCI_BW = HCI_DW / 8;
  localparam int HCI_UW = 2;

  // idx is sized for the largest supported initiator count; wen is kept verbatim (1 = read)
  typedef struct packed {
    logic [HCI_ARB_IDX_W-1:0] idx;
    logic                     wen;
  } hci_arb_id_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hci_core_resp_tracking_arbiter_if.sv
// HCI core request/response bundle; initiator drives requests, target answers.
interface hci_core_resp_tracking_arbiter_if;
  import hci_core_resp_tracking_arbiter_pkg::*;

  logic              req;
  logic              gnt;
  logic [HCI_AW-1:0] add;
  logic              wen;
  logic [HCI_DW-1:0] data;
  logic [HCI_BW-1:0] be;
  logic [HCI_UW-1:0] user;
  logic              lrdy;
  logic              r_valid;
  logic [HCI_DW-1:0] r_data;
  logic              r_opc;
  logic [HCI_UW-1:0] r_user;

  modport initiator (
    output req, add, wen, data, be, user, lrdy,
    input  gnt, r_valid, r_data, r_opc, r_user
  );

  modport target (
    input  req, add, wen, data, be, user, lrdy,
    output gnt, r_valid, r_data, r_opc, r_user
  );

endinterface

// File: rtl/hci_core_arb_id_fifo.sv
// In-order FIFO of granted transaction IDs; the head names the initiator
// owning the next response. Push is ignored when full, pop when empty.
module hci_core_arb_id_fifo
  import hci_core_resp_tracking_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  hci_arb_id_t data_i,
  input  logic        pop_i,
  output hci_arb_id_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  hci_arb_id_t   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          push_s;
  logic          pop_s;

  assign full_o  = (cnt_r == CW'(DEPTH));
  assign empty_o = (cnt_r == {CW{1'b0}});
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_r[rd_ptr_r];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (clear_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {(HCI_ARB_IDX_W + 1){1'b0}};
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule

// File: rtl/hci_core_resp_tracking_arbiter.sv
// Round-robin arbiter sharing one HCI core port among N_INIT initiators, with
// in-order response routing. Optional perf counters: define HCI_ARB_PERF_CNT_EN.
module hci_core_resp_tracking_arbiter
  import hci_core_resp_tracking_arbiter_pkg::*;
#(
  parameter int N_INIT          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FILTER_WRITES   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [N_INIT-1:0]      filter_en_i,
  hci_core_resp_tracking_arbiter_if.target    tcdm_slave [N_INIT],
  hci_core_resp_tracking_arbiter_if.initiator tcdm_master,
  output logic                   busy_o,
  output logic                   spurious_rsp_o
`ifdef HCI_ARB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_gnt_o   [N_INIT],
  output logic [31:0]            perf_stall_o [N_INIT]
`endif
);

  localparam int IW = (N_INIT > 1) ? $clog2(N_INIT) : 1;

  logic [N_INIT-1:0] req_s;
  logic [N_INIT-1:0] wen_s;
  logic [N_INIT-1:0] lrdy_s;
  logic [HCI_AW-1:0] add_s  [N_INIT];
  logic [HCI_DW-1:0] data_s [N_INIT];
  logic [HCI_BW-1:0] be_s   [N_INIT];
  logic [HCI_UW-1:0] user_s [N_INIT];
  logic [N_INIT-1:0] gnt_s;
  logic [N_INIT-1:0] rvalid_s;

  logic [IW-1:0] rr_ptr_r;
  logic [IW-1:0] win_s;
  logic          mreq_s;
  logic          hs_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          spurious_r;
  hci_arb_id_t   push_id_s;
  hci_arb_id_t   head_s;

  for (genvar g = 0; g < N_INIT; g++) begin : g_slave
    assign req_s[g]  = tcdm_slave[g].req;
    assign wen_s[g]  = tcdm_slave[g].wen;
    assign lrdy_s[g] = tcdm_slave[g].lrdy;
    assign add_s[g]  = tcdm_slave[g].add;
    assign data_s[g] = tcdm_slave[g].data;
    assign be_s[g]   = tcdm_slave[g].be;
    assign user_s[g] = tcdm_slave[g].user;

    assign tcdm_slave[g].gnt     = gnt_s[g];
    assign tcdm_slave[g].r_valid = rvalid_s[g];
    assign tcdm_slave[g].r_data  = tcdm_master.r_data;
    assign tcdm_slave[g].r_opc   = tcdm_master.r_opc;
    assign tcdm_slave[g].r_user  = tcdm_master.r_user;
  end

  // Scan downwards so the requester closest at-or-after rr_ptr is the last write
  always_comb begin
    logic [IW-1:0] cand_v;
    cand_v = {IW{1'b0}};
    win_s  = rr_ptr_r;
    for (int k = N_INIT - 1; k >= 0; k--) begin
      cand_v = IW'((int'(rr_ptr_r) + k) % N_INIT);
      win_s  = req_s[cand_v] ? cand_v : win_s;
    end
  end

  // Full blocks requests even when a pop is pending, keeping r_valid off the req path
  assign mreq_s = (|req_s) & ~full_s & ~clear_i;
  assign hs_s   = mreq_s & tcdm_master.gnt;
  assign pop_s  = tcdm_master.r_valid & ~empty_s & ~clear_i;

  assign tcdm_master.req  = mreq_s;
  assign tcdm_master.add  = add_s[win_s];
  assign tcdm_master.data = data_s[win_s];
  assign tcdm_master.be   = be_s[win_s];
  assign tcdm_master.wen  = wen_s[win_s];
  assign tcdm_master.user = user_s[win_s];
  assign tcdm_master.lrdy = lrdy_s[win_s];

  assign push_id_s.idx = HCI_ARB_IDX_W'(win_s);
  assign push_id_s.wen = wen_s[win_s];

  always_comb begin
    gnt_s    = {N_INIT{1'b0}};
    rvalid_s = {N_INIT{1'b0}};
    for (int g = 0; g < N_INIT; g++) begin
      gnt_s[g]    = hs_s && (win_s == IW'(g));
      rvalid_s[g] = pop_s && (head_s.idx == HCI_ARB_IDX_W'(g)) &&
                    !(FILTER_WRITES && filter_en_i[g] && !head_s.wen);
    end
  end

  hci_core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (hs_s),
    .data_i  (push_id_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r   <= {IW{1'b0}};
      spurious_r <= 1'b0;
    end else if (clear_i) begin
      rr_ptr_r   <= {IW{1'b0}};
      spurious_r <= 1'b0;
    end else begin
      if (hs_s) begin
        rr_ptr_r <= (win_s == IW'(N_INIT - 1)) ? {IW{1'b0}} : win_s + IW'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (tcdm_master.r_valid && empty_s) spurious_r <= 1'b1;
      else                                spurious_r <= spurious_r;
    end
  end

  assign busy_o         = ~empty_s;
  assign spurious_rsp_o = spurious_r;

`ifdef HCI_ARB_PERF_CNT_EN
  logic [31:0] perf_gnt_r   [N_INIT];
  logic [31:0] perf_stall_r [N_INIT];

  for (genvar g = 0; g < N_INIT; g++) begin : g_perf
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perf_gnt_r[g]   <= 32'd0;
        perf_stall_r[g] <= 32'd0;
      end else if (clear_i) begin
        perf_gnt_r[g]   <= 32'd0;
        perf_stall_r[g] <= 32'd0;
      end else begin
        perf_gnt_r[g]   <= gnt_s[g] ? sat_inc32(perf_gnt_r[g]) : perf_gnt_r[g];
        perf_stall_r[g] <= (req_s[g] && !gnt_s[g]) ? sat_inc32(perf_stall_r[g]) : perf_stall_r[g];
      end
    end
    assign perf_gnt_o[g]   = perf_gnt_r[g];
    assign perf_stall_o[g] = perf_stall_r[g];
  end
`endif

endmodule

// File: tb/tb_hci_core_resp_tracking_arbiter.sv
// Directed self-checking bench for hci_core_resp_tracking_arbiter (N_INIT=2, MAX_OUTSTANDING=4).
module tb_hci_core_resp_tracking_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [1:0] filt;
  logic       busy;
  logic       spur;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  hci_core_resp_tracking_arbiter_if slv_if [2] ();
  hci_core_resp_tracking_arbiter_if mst_if ();

`ifdef HCI_ARB_PERF_CNT_EN
  logic [31:0] perf_gnt   [2];
  logic [31:0] perf_stall [2];
`endif

  hci_core_resp_tracking_arbiter #(
    .N_INIT          (2),
    .MAX_OUTSTANDING (4),
    .FILTER_WRITES   (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .filter_en_i    (filt),
    .tcdm_slave     (slv_if),
    .tcdm_master    (mst_if),
    .busy_o         (busy),
    .spurious_rsp_o (spur)
`ifdef HCI_ARB_PERF_CNT_EN
    ,
    .perf_gnt_o     (perf_gnt),
    .perf_stall_o   (perf_stall)
`endif
  );

  wire [1:0] s_gnt = {slv_if[1].gnt, slv_if[0].gnt};
  wire [1:0] s_rv  = {slv_if[1].r_valid, slv_if[0].r_valid};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] req, input logic [1:0] wen);
    slv_if[0].req = req[0];
    slv_if[1].req = req[1];
    slv_if[0].wen = wen[0];
    slv_if[1].wen = wen[1];
  endtask

  task automatic idle();
    set_req(2'b00, 2'b11);
    mst_if.gnt     = 1'b0;
    mst_if.r_valid = 1'b0;
    mst_if.r_data  = 32'h0;
    mst_if.r_opc   = 1'b0;
    mst_if.r_user  = 2'b00;
    clear          = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    filt  = 2'b00;
    idle();
    slv_if[0].add = 32'h100; slv_if[1].add = 32'h200;
    slv_if[0].data = 32'hA0; slv_if[1].data = 32'hA1;
    slv_if[0].be = 4'hF; slv_if[1].be = 4'hF;
    slv_if[0].user = 2'b01; slv_if[1].user = 2'b10;
    slv_if[0].lrdy = 1'b1; slv_if[1].lrdy = 1'b1;
    tick();
    tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (spur !== 1'b0) $display("FAIL reset_spur: got %b want 0", spur); else pass_cnt++;
    chk_cnt++; if (mst_if.req !== 1'b0) $display("FAIL reset_mreq: got %b want 0", mst_if.req); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (s_gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", s_gnt); else pass_cnt++;
  endtask

  task automatic test_rr_reads();
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [31:0] exp_add;
    for (int k = 0; k < 5; k++) begin
      set_req((k < 4) ? 2'b11 : 2'b00, 2'b11);
      mst_if.gnt     = 1'b1;
      mst_if.r_valid = (k > 0);
      mst_if.r_data  = 32'hD000 + k;
      #1;
      exp_gnt = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_rv  = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      exp_add = (k % 2 == 0) ? 32'h100 : 32'h200;
      chk_cnt++; if (s_gnt !== exp_gnt) $display("FAIL rr_gnt[%0d]: got %b want %b", k, s_gnt, exp_gnt); else pass_cnt++;
      chk_cnt++; if (s_rv !== exp_rv) $display("FAIL rr_rvalid[%0d]: got %b want %b", k, s_rv, exp_rv); else pass_cnt++;
      if (k < 4) begin
        chk_cnt++; if (mst_if.add !== exp_add) $display("FAIL rr_add[%0d]: got %h want %h", k, mst_if.add, exp_add); else pass_cnt++;
      end
      if (k > 0) begin
        chk_cnt++; if (slv_if[1].r_data !== 32'hD000 + k) $display("FAIL rr_rdata[%0d]: got %h want %h", k, slv_if[1].r_data, 32'hD000 + k); else pass_cnt++;
      end
      tick();
    end
    idle();
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rr_drained: got busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_filter();
    filt = 2'b01;
    set_req(2'b01, 2'b00);
    mst_if.gnt = 1'b1;
    #1;
    chk_cnt++; if (s_gnt !== 2'b01) $display("FAIL flt_gnt0: got %b want 01", s_gnt); else pass_cnt++;
    tick();
    idle(); mst_if.r_valid = 1'b1;
    #1;
    chk_cnt++; if (s_rv !== 2'b00) $display("FAIL flt_suppress0: got %b want 00", s_rv); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL flt_busy: got %b want 1", busy); else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL flt_popped: got busy %b want 0", busy); else pass_cnt++;
    set_req(2'b10, 2'b00); mst_if.gnt = 1'b1;
    #1;
    chk_cnt++; if (s_gnt !== 2'b10) $display("FAIL flt_gnt1: got %b want 10", s_gnt); else pass_cnt++;
    tick();
    idle(); mst_if.r_valid = 1'b1;
    #1;
    chk_cnt++; if (s_rv !== 2'b10) $display("FAIL flt_forward1: got %b want 10", s_rv); else pass_cnt++;
    tick();
    set_req(2'b01, 2'b11); mst_if.gnt = 1'b1; mst_if.r_valid = 1'b0;
    tick();
    idle(); mst_if.r_valid = 1'b1;
    #1;
    chk_cnt++; if (s_rv !== 2'b01) $display("FAIL flt_read0: got %b want 01", s_rv); else pass_cnt++;
    tick();
    idle();
    filt = 2'b00;
  endtask

  task automatic test_full();
    int n_gnt = 0;
    set_req(2'b01, 2'b11);
    mst_if.gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (s_gnt[0] === 1'b1) n_gnt++;
      if (k == 4) begin
        chk_cnt++; if (mst_if.req !== 1'b0) $display("FAIL full_mreq: got %b want 0", mst_if.req); else pass_cnt++;
      end
      tick();
    end
    chk_cnt++; if (n_gnt !== 4) $display("FAIL full_grants: got %0d want 4", n_gnt); else pass_cnt++;
    mst_if.r_valid = 1'b1;
    #1;
    chk_cnt++; if (s_gnt !== 2'b00) $display("FAIL full_pop_gnt: got %b want 00", s_gnt); else pass_cnt++;
    chk_cnt++; if (s_rv !== 2'b01) $display("FAIL full_pop_rv: got %b want 01", s_rv); else pass_cnt++;
    tick();
    mst_if.r_valid = 1'b0;
    #1;
    chk_cnt++; if (s_gnt !== 2'b01) $display("FAIL full_fifth_gnt: got %b want 01", s_gnt); else pass_cnt++;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      mst_if.r_valid = 1'b1;
      #1;
      chk_cnt++; if (s_rv !== 2'b01) $display("FAIL full_drain[%0d]: got %b want 01", k, s_rv); else pass_cnt++;
      tick();
    end
    idle();
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL full_empty: got busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_spurious();
    idle(); mst_if.r_valid = 1'b1;
    #1;
    chk_cnt++; if (s_rv !== 2'b00) $display("FAIL spur_rv: got %b want 00", s_rv); else pass_cnt++;
    tick();
    mst_if.r_valid = 1'b0;
    #1;
    chk_cnt++; if (spur !== 1'b1) $display("FAIL spur_set: got %b want 1", spur); else pass_cnt++;
    tick(); tick(); tick();
    chk_cnt++; if (spur !== 1'b1) $display("FAIL spur_sticky: got %b want 1", spur); else pass_cnt++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk_cnt++; if (spur !== 1'b0) $display("FAIL spur_clear: got %b want 0", spur); else pass_cnt++;
  endtask

  task automatic test_clear();
    set_req(2'b10, 2'b11); mst_if.gnt = 1'b1;
    tick(); tick(); tick();
    set_req(2'b01, 2'b11); clear = 1'b1;
    #1;
    chk_cnt++; if (s_gnt !== 2'b00) $display("FAIL clr_gnt: got %b want 00", s_gnt); else pass_cnt++;
    chk_cnt++; if (mst_if.req !== 1'b0) $display("FAIL clr_mreq: got %b want 0", mst_if.req); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL clr_busy_before: got %b want 1", busy); else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL clr_busy_after: got %b want 0", busy); else pass_cnt++;
    mst_if.r_valid = 1'b1;
    #1;
    chk_cnt++; if (s_rv !== 2'b00) $display("FAIL clr_rv: got %b want 00", s_rv); else pass_cnt++;
    tick();
    mst_if.r_valid = 1'b0;
    #1;
    chk_cnt++; if (spur !== 1'b1) $display("FAIL clr_spur: got %b want 1", spur); else pass_cnt++;
    clear = 1'b1;
    tick();
    idle();
  endtask

`ifdef HCI_ARB_PERF_CNT_EN
  task automatic test_perf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk_cnt++; if (perf_stall[1] !== 32'd0) $display("FAIL perf_clr: got %0d want 0", perf_stall[1]); else pass_cnt++;
    set_req(2'b11, 2'b11); mst_if.gnt = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    mst_if.gnt = 1'b1;
    #1;
    chk_cnt++; if (s_gnt !== 2'b01) $display("FAIL perf_win0: got %b want 01", s_gnt); else pass_cnt++;
    tick();
    idle(); mst_if.r_valid = 1'b1;
    tick();
    idle();
    #1;
    chk_cnt++; if (perf_gnt[0] !== 32'd1) $display("FAIL perf_gnt0: got %0d want 1", perf_gnt[0]); else pass_cnt++;
    chk_cnt++; if (perf_gnt[1] !== 32'd0) $display("FAIL perf_gnt1: got %0d want 0", perf_gnt[1]); else pass_cnt++;
    chk_cnt++; if (perf_stall[0] !== 32'd10) $display("FAIL perf_stall0: got %0d want 10", perf_stall[0]); else pass_cnt++;
    chk_cnt++; if (perf_stall[1] !== 32'd11) $display("FAIL perf_stall1: got %0d want 11", perf_stall[1]); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_rr_reads();
    test_filter();
    test_full();
    test_spurious();
    test_clear();
`ifdef HCI_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
